// File: rtl/tt_mux_slot_sel.sv
// tt_mux_slot_sel: N-slot project multiplexer with safe switchover.
// The pad input bus goes to every slot. A one-hot enable picks one slot, and
// that slot's output bus is returned. On a switch the old slot is disabled for
// one cycle. The new slot is then held in project reset for RST_CYCLES cycles
// before it is released.
module tt_mux_slot_sel #(
  parameter int unsigned N_SLOTS    = 16,
  parameter int unsigned SEL_W      = 4,
  parameter int unsigned IW_W       = 18,
  parameter int unsigned OW_W       = 24,
  parameter int unsigned RST_CYCLES = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sel_valid,
  input  logic [SEL_W-1:0]         sel_addr,
  output logic                     sel_ready,
  input  logic [IW_W-1:0]          iw_in,
  output logic [OW_W-1:0]          ow_out,
  output logic [N_SLOTS-1:0]       slot_ena,
  output logic [IW_W-1:0]          slot_iw,
  input  logic [N_SLOTS*OW_W-1:0]  slot_ow,
  output logic [SEL_W-1:0]         active_slot,
  output logic                     active_valid
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_SWITCH_OFF = 2'd1,
    ST_HOLD_RST   = 2'd2,
    ST_ACTIVE     = 2'd3
  } state_e;

  state_e            state_q;
  logic [SEL_W-1:0]  target_q;
  logic              target_ok_q;
  logic [CNT_W-1:0]  hold_cnt_q;

  logic              accept_c;
  logic              addr_ok_c;
  logic [IW_W-1:0]   iw_held_c;
  logic [OW_W-1:0]   sel_ow_c;

  // Decode the handshake and the range of the requested address.
  always_comb begin
    accept_c  = sel_valid && sel_ready;
    addr_ok_c = (32'(sel_addr) < N_SLOTS);
  end

  // Copy of the pad bus with project rst_n (bit 1) forced low. The clock bit still passes.
  always_comb begin
    iw_held_c    = iw_in;
    iw_held_c[1] = 1'b0;
  end

  // Pick the active slot's output bus. An index outside the slot range gives zero.
  always_comb begin
    sel_ow_c = '0;
    for (int unsigned k = 0; k < N_SLOTS; k++) begin
      if (active_slot == SEL_W'(k)) begin
        sel_ow_c = slot_ow[k*OW_W +: OW_W];
      end
    end
  end

  // Build the one-hot enable for a slot index.
  function automatic logic [N_SLOTS-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [N_SLOTS-1:0] v;
    v = '0;
    for (int unsigned k = 0; k < N_SLOTS; k++) begin
      if (idx == SEL_W'(k)) v[k] = 1'b1;
    end
    return v;
  endfunction

  // Switchover FSM. Every output is registered to match the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      target_q     <= '0;
      target_ok_q  <= 1'b0;
      hold_cnt_q   <= '0;
      sel_ready    <= 1'b1;
      slot_ena     <= '0;
      slot_iw      <= '0;
      ow_out       <= '0;
      active_slot  <= '0;
      active_valid <= 1'b0;
    end else begin
      // Return path: one cycle behind slot_ow, and zero unless a slot is enabled.
      if (state_q == ST_HOLD_RST || state_q == ST_ACTIVE) begin
        ow_out <= sel_ow_c;
      end else begin
        ow_out <= '0;
      end

      case (state_q)
        ST_IDLE: begin
          slot_ena     <= '0;
          slot_iw      <= '0;
          active_valid <= 1'b0;
          // An out-of-range address is accepted, but it is already the deselected state.
          if (accept_c && addr_ok_c) begin
            state_q     <= ST_SWITCH_OFF;
            target_q    <= sel_addr;
            target_ok_q <= 1'b1;
            sel_ready   <= 1'b0;
          end
        end

        ST_SWITCH_OFF: begin
          if (target_ok_q) begin
            state_q     <= ST_HOLD_RST;
            hold_cnt_q  <= CNT_W'(RST_CYCLES);
            slot_ena    <= onehot(target_q);
            active_slot <= target_q;
            slot_iw     <= iw_held_c;
            sel_ready   <= 1'b0;
          end else begin
            state_q     <= ST_IDLE;
            slot_ena    <= '0;
            slot_iw     <= '0;
            active_slot <= '0;
            sel_ready   <= 1'b1;
          end
        end

        ST_HOLD_RST: begin
          if (hold_cnt_q <= CNT_W'(1)) begin
            state_q      <= ST_ACTIVE;
            hold_cnt_q   <= '0;
            slot_iw      <= iw_in;
            active_valid <= 1'b1;
            sel_ready    <= 1'b1;
          end else begin
            hold_cnt_q   <= hold_cnt_q - CNT_W'(1);
            slot_iw      <= iw_held_c;
          end
        end

        ST_ACTIVE: begin
          // Any accepted request, including the same slot, restarts from switch-off.
          if (accept_c) begin
            state_q      <= ST_SWITCH_OFF;
            target_q     <= sel_addr;
            target_ok_q  <= addr_ok_c;
            slot_ena     <= '0;
            slot_iw      <= '0;
            active_valid <= 1'b0;
            sel_ready    <= 1'b0;
          end else begin
            slot_iw      <= iw_in;
          end
        end

        default: begin
          state_q      <= ST_IDLE;
          slot_ena     <= '0;
          slot_iw      <= '0;
          active_valid <= 1'b0;
          sel_ready    <= 1'b1;
        end
      endcase
    end
  end

endmodule
